accel_bus_scheduler: RTL and testbench

Time-slices the shared 32-bit RAM data bus between the FFT, FIR and IIR accelerators. Drives the one-hot `fft_enable`/`fir_enable`/`iir_enable` inputs of the data bus controller using round-robin arbitration. Each grant is bounded by a word quota and an idle timeout. Every hand-over passes through a guard gap so in-flight RAM read/write and FIFO put/get requests retire before ownership changes.

---
 rtl/accel_bus_pkg.sv | 47 ++++
 rtl/accel_bus_scheduler_if.sv | 23 ++
 rtl/accel_bus_scheduler_rr_pick3.sv | 28 ++
 rtl/accel_bus_scheduler.sv | 138 +++++++++++++
 tb/tb_accel_bus_scheduler.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/accel_bus_pkg.sv
// rtl/accel_bus_pkg.sv - shared types, ids and helpers for the accelerator bus scheduler
package accel_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] ID_FFT  = 2'd0;
    localparam logic [1:0] ID_FIR  = 2'd1;
    localparam logic [1:0] ID_IIR  = 2'd2;
    localparam logic [1:0] ID_NONE = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_REQ     = 2'd1;
    localparam logic [1:0] CAUSE_QUOTA   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    // Round-robin successor; ID_NONE falls back to FFT so it never stalls the search.
    function automatic logic [1:0] next_id(input logic [1:0] id);
        case (id)
            ID_FFT:  next_id = ID_FIR;
            ID_FIR:  next_id = ID_IIR;
            default: next_id = ID_FFT;
        endcase
    endfunction

    function automatic logic req_of(input logic [2:0] req, input logic [1:0] id);
        case (id)
            ID_FFT:  req_of = req[0];
            ID_FIR:  req_of = req[1];
            ID_IIR:  req_of = req[2];
            default: req_of = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
        case (id)
            ID_FFT:  id_to_onehot = 3'b001;
            ID_FIR:  id_to_onehot = 3'b010;
            ID_IIR:  id_to_onehot = 3'b100;
            default: id_to_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/accel_bus_scheduler_if.sv
// rtl/accel_bus_scheduler_if.sv - request/enable signal bundle between accelerators and the scheduler
interface accel_bus_scheduler_if;
    logic       fft_req;
    logic       fir_req;
    logic       iir_req;
    logic       word_xfer;
    logic       fft_enable;
    logic       fir_enable;
    logic       iir_enable;
    logic [1:0] grant_id;
    logic       busy;
    logic [1:0] release_cause;

    modport master (
        input  fft_req, fir_req, iir_req, word_xfer,
        output fft_enable, fir_enable, iir_enable, grant_id, busy, release_cause
    );

    modport slave (
        output fft_req, fir_req, iir_req, word_xfer,
        input  fft_enable, fir_enable, iir_enable, grant_id, busy, release_cause
    );
endinterface

// File: rtl/accel_bus_scheduler_rr_pick3.sv
// rtl/accel_bus_scheduler_rr_pick3.sv - three-way round-robin picker, searching from last_id+1
module rr_pick3
    import accel_bus_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_id_i,
    output logic       valid_o,
    output logic [1:0] pick_id_o
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        valid_o   = |req_i;
        pick_id_o = ID_NONE;
        found     = 1'b0;
        cand      = next_id(last_id_i);
        for (int i = 0; i < 3; i++) begin
            if (!found && req_of(req_i, cand)) begin
                pick_id_o = cand;
                found     = 1'b1;
            end
            cand = next_id(cand);
        end
    end

endmodule

// File: rtl/accel_bus_scheduler.sv
// rtl/accel_bus_scheduler.sv - round-robin time-slicing of the shared RAM bus with quota, timeout and guard gap
module accel_bus_scheduler
    import accel_bus_pkg::*;
#(
    parameter int BURST_LEN    = 16,
    parameter int IDLE_TIMEOUT = 32,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    accel_bus_scheduler_if.master bus
);

    localparam int WCW = $clog2(BURST_LEN + 1);
    localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    localparam logic [WCW-1:0] BURST_W  = WCW'(BURST_LEN);
    localparam logic [ICW-1:0] IDLE_W   = ICW'(IDLE_TIMEOUT);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

    state_t         state_q, state_d;
    logic [1:0]     last_id_q, last_id_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     cause_q, cause_d;
    logic [2:0]     en_q, en_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic [GCW-1:0] gap_cnt_q, gap_cnt_d;

    logic [2:0]     req_vec;
    logic           pick_valid;
    logic [1:0]     pick_id;
    logic [WCW-1:0] word_sum;
    logic [ICW-1:0] idle_sum;
    logic           release_now;
    logic [1:0]     release_cause;

    assign req_vec = {bus.iir_req, bus.fir_req, bus.fft_req};

    rr_pick3 u_pick (
        .req_i     (req_vec),
        .last_id_i (last_id_q),
        .valid_o   (pick_valid),
        .pick_id_o (pick_id)
    );

    // The transfer of the current cycle is folded in before comparing, so a release never loses a word.
    assign word_sum = word_cnt_q + WCW'(bus.word_xfer);
    assign idle_sum = idle_cnt_q + ICW'(!bus.word_xfer);

    always_comb begin
        release_now   = 1'b1;
        release_cause = CAUSE_NONE;
        if (!req_of(req_vec, grant_q)) begin
            release_cause = CAUSE_REQ;
        end else if (word_sum == BURST_W) begin
            release_cause = CAUSE_QUOTA;
        end else if (idle_sum == IDLE_W) begin
            release_cause = CAUSE_TIMEOUT;
        end else begin
            release_now = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        grant_d    = grant_q;
        cause_d    = cause_q;
        en_d       = en_q;
        word_cnt_d = word_cnt_q;
        idle_cnt_d = idle_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    grant_d    = pick_id;
                    last_id_d  = pick_id;
                    en_d       = id_to_onehot(pick_id);
                    word_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d   = GAP;
                    en_d      = 3'b000;
                    grant_d   = ID_NONE;
                    cause_d   = release_cause;
                    gap_cnt_d = GAP_LAST;
                end else begin
                    word_cnt_d = word_sum;
                    idle_cnt_d = bus.word_xfer ? '0 : idle_sum;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_id_q  <= ID_IIR;
            grant_q    <= ID_NONE;
            cause_q    <= CAUSE_NONE;
            en_q       <= 3'b000;
            word_cnt_q <= '0;
            idle_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            grant_q    <= grant_d;
            cause_q    <= cause_d;
            en_q       <= en_d;
            word_cnt_q <= word_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign bus.fft_enable    = en_q[0];
    assign bus.fir_enable    = en_q[1];
    assign bus.iir_enable    = en_q[2];
    assign bus.grant_id      = grant_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.release_cause = cause_q;

endmodule

// File: tb/tb_accel_bus_scheduler.sv
// tb/tb_accel_bus_scheduler.sv - directed self-checking bench for accel_bus_scheduler
module tb_accel_bus_scheduler;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    accel_bus_scheduler_if bus ();

    accel_bus_scheduler #(
        .BURST_LEN    (16),
        .IDLE_TIMEOUT (32),
        .GAP_CYCLES   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (bus.grant_id == 2'd3 && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic hold_len(output int len);
        len = 0;
        while (bus.grant_id != 2'd3 && len < 200) begin
            step();
            len++;
        end
    endtask

    function automatic int en_vec();
        return int'({bus.iir_enable, bus.fir_enable, bus.fft_enable});
    endfunction

    // Enable vector and grant_id must agree on every cycle, whatever the stimulus.
    always @(negedge clk) begin
        logic [2:0] e;
        int         exp_id;
        e = {bus.iir_enable, bus.fir_enable, bus.fft_enable};
        case (e)
            3'b001:  exp_id = 0;
            3'b010:  exp_id = 1;
            3'b100:  exp_id = 2;
            default: exp_id = 3;
        endcase
        check("onehot", int'($countones(e) <= 1), 1);
        if ($countones(e) <= 1)
            check("grant_id_vs_enable", int'(bus.grant_id), exp_id);
    end

    initial begin
        int c;
        int len;
        int exp_order[3];
        n_checks = 0;
        n_fail   = 0;
        exp_order[0] = 1;
        exp_order[1] = 2;
        exp_order[2] = 0;

        reset = 1'b1;
        bus.fft_req = 1'b0;
        bus.fir_req = 1'b0;
        bus.iir_req = 1'b0;
        bus.word_xfer = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("reset_en", en_vec(), 0);
        check("reset_grant_id", int'(bus.grant_id), 3);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_cause", int'(bus.release_cause), 0);

        // Lone FFT requester, transfer every cycle
        bus.fft_req = 1'b1;
        bus.word_xfer = 1'b1;
        wait_grant(c);
        check("t1_req_latency", c, 1);
        check("t1_grant_fft", int'(bus.grant_id), 0);
        check("t1_busy", int'(bus.busy), 1);
        hold_len(len);
        check("t1_quota_len", len, 16);
        check("t1_cause_quota", int'(bus.release_cause), 2);
        check("t1_gap_en", en_vec(), 0);
        check("t1_gap_busy", int'(bus.busy), 1);
        wait_grant(c);
        check("t1_handover", c, 3);
        check("t1_regrant_fft", int'(bus.grant_id), 0);
        check("t1_cause_held", int'(bus.release_cause), 2);

        // All three requesting: FFT (current), FIR, IIR, FFT
        bus.fir_req = 1'b1;
        bus.iir_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hold_len(len);
            check("t2_quota_len", len, 16);
            check("t2_cause", int'(bus.release_cause), 2);
            check("t2_gap1_en", en_vec(), 0);
            step();
            check("t2_gap2_en", en_vec(), 0);
            check("t2_gap2_busy", int'(bus.busy), 1);
            wait_grant(c);
            check("t2_gap_exit", c, 2);
            check("t2_order", int'(bus.grant_id), exp_order[i]);
        end

        // FFT drops its request, FIR then times out
        bus.fft_req = 1'b0;
        bus.iir_req = 1'b0;
        bus.word_xfer = 1'b0;
        hold_len(len);
        check("t3_drop_len", len, 1);
        check("t3_cause_req", int'(bus.release_cause), 1);
        wait_grant(c);
        check("t3_handover", c, 3);
        check("t3_grant_fir", int'(bus.grant_id), 1);
        hold_len(len);
        check("t3_timeout_len", len, 32);
        check("t3_cause_timeout", int'(bus.release_cause), 3);
        check("t3_grant_none", int'(bus.grant_id), 3);

        // IIR drops its request on the fifth word
        bus.fir_req = 1'b0;
        bus.iir_req = 1'b1;
        wait_grant(c);
        check("t4_grant_iir", int'(bus.grant_id), 2);
        bus.word_xfer = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t4_still_iir", int'(bus.grant_id), 2);
        bus.iir_req = 1'b0;
        bus.fft_req = 1'b1;
        step();
        check("t4_released", int'(bus.grant_id), 3);
        check("t4_cause_req", int'(bus.release_cause), 1);
        wait_grant(c);
        check("t4_next_fft", int'(bus.grant_id), 0);

        // Request dropped in the same cycle the quota is reached: req wins
        for (int i = 0; i < 15; i++) step();
        check("t5_before_quota", int'(bus.grant_id), 0);
        bus.fft_req = 1'b0;
        step();
        check("t5_released", int'(bus.grant_id), 3);
        check("t5_cause_req_wins", int'(bus.release_cause), 1);

        // Reset in the middle of a grant
        bus.fft_req = 1'b1;
        wait_grant(c);
        check("t6_grant_fft", int'(bus.grant_id), 0);
        for (int i = 0; i < 7; i++) step();
        bus.fir_req = 1'b1;
        bus.iir_req = 1'b1;
        reset = 1'b1;
        step();
        check("t6_reset_en", en_vec(), 0);
        check("t6_reset_grant", int'(bus.grant_id), 3);
        check("t6_reset_cause", int'(bus.release_cause), 0);
        check("t6_reset_busy", int'(bus.busy), 0);
        reset = 1'b0;
        wait_grant(c);
        check("t6_first_latency", c, 1);
        check("t6_first_fft", int'(bus.grant_id), 0);

        // Random traffic, policed by the per-cycle monitor
        for (int i = 0; i < 400; i++) begin
            bus.fft_req   = 1'($urandom_range(0, 1));
            bus.fir_req   = 1'($urandom_range(0, 1));
            bus.iir_req   = 1'($urandom_range(0, 1));
            bus.word_xfer = 1'($urandom_range(0, 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
